// File: rtl/accum_pkg.sv
// Shared types and constants for the accum_stream16 packet accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int CNT_W_DEF  = 8;
    localparam int BEAT_W_DEF = 16;

    localparam logic [15:0] ZERO_OPND = 16'h0000;

endpackage

// File: rtl/cla16bit.sv
// 16-bit recursive-doubling (Kogge-Stone) adder, no carry-in.
module cla16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Sum,
    output logic        cout
);

    function automatic logic [16:0] ks_add(input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] gn;
        logic [15:0] pn;
        logic [15:0] p0;
        int          d;
        g  = a & b;
        p  = a ^ b;
        p0 = p;
        for (int l = 0; l < 4; l++) begin
            d = 1 << l;
            for (int i = 0; i < 16; i++) begin
                if (i >= d) begin
                    gn[i] = g[i] | (p[i] & g[i-d]);
                    pn[i] = p[i] & p[i-d];
                end else begin
                    gn[i] = g[i];
                    pn[i] = p[i];
                end
            end
            g = gn;
            p = pn;
        end
        // g[i] is now the carry out of bit i
        return {g[15], p0 ^ {g[14:0], 1'b0}};
    endfunction

    assign {cout, Sum} = ks_add(A, B);

endmodule

// File: rtl/accum_stream16.sv
// Packet accumulator behind cla16bit; carry-outs counted into the upper field.
// Define ACCUM_SAT_EN to saturate out_data to all-ones on counter overflow.
module accum_stream16
    import accum_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16+CNT_W-1:0] out_data,
    output logic                out_ovf,
    output logic [BEAT_W-1:0]   out_beats
);

    state_t              state_q, state_d;
    logic [15:0]         lo_q, lo_d;
    logic [CNT_W-1:0]    hi_q, hi_d;
    logic                ovf_q, ovf_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [16+CNT_W-1:0] res_q, res_d;
    logic                rovf_q, rovf_d;
    logic [BEAT_W-1:0]   rbeats_q, rbeats_d;

    logic                idle;
    logic                accept;
    logic [15:0]         op_a;
    logic [15:0]         sum;
    logic                cout;
    logic [CNT_W-1:0]    base_hi, nxt_hi;
    logic                base_ovf, nxt_ovf;
    logic [BEAT_W-1:0]   base_beats, nxt_beats;
    logic [16+CNT_W-1:0] nxt_res;

    cla16bit u_add (
        .A    (op_a),
        .B    (in_data),
        .Sum  (sum),
        .cout (cout)
    );

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_ovf   = rovf_q;
    assign out_beats = rbeats_q;
    assign accept    = in_valid & in_ready;

    always_comb begin
        idle       = (state_q == IDLE);
        op_a       = idle ? ZERO_OPND : lo_q;
        base_hi    = idle ? '0 : hi_q;
        base_ovf   = idle ? 1'b0 : ovf_q;
        base_beats = idle ? '0 : beats_q;
        nxt_hi     = base_hi + CNT_W'(cout);
        nxt_ovf    = base_ovf | (cout & (&base_hi));
        nxt_beats  = (&base_beats) ? base_beats
                                   : base_beats + BEAT_W'(1);
`ifdef ACCUM_SAT_EN
        nxt_res    = nxt_ovf ? '1 : {nxt_hi, sum};
`else
        nxt_res    = {nxt_hi, sum};
`endif

        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        beats_d  = beats_q;
        res_d    = res_q;
        rovf_d   = rovf_q;
        rbeats_d = rbeats_q;

        if (accept) begin
            lo_d    = sum;
            hi_d    = nxt_hi;
            ovf_d   = nxt_ovf;
            beats_d = nxt_beats;
            if (in_last) begin
                state_d  = DONE;
                res_d    = nxt_res;
                rovf_d   = nxt_ovf;
                rbeats_d = nxt_beats;
            end else begin
                state_d = ACCUM;
            end
        end else if (out_valid && out_ready) begin
            state_d = IDLE;
            lo_d    = '0;
            hi_d    = '0;
            ovf_d   = 1'b0;
            beats_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            beats_q  <= '0;
            res_q    <= '0;
            rovf_q   <= 1'b0;
            rbeats_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            beats_q  <= beats_d;
            res_q    <= res_d;
            rovf_q   <= rovf_d;
            rbeats_q <= rbeats_d;
        end
    end

endmodule
